rate_seq_ctrl: RTL and testbench
================================

RATE_SEQ_CTRL -- requirements
Module: rate_seq_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4: length in clk cycles of the all-enables-low gap between rates; legal range >=1.
REQ-002 SHALL have parameter SET_TIMEOUT, default 5000: length in clk cycles of SET-mode inactivity before auto-return to CLOCK; legal range >=2.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port btn_mode, input, 1 bit: raw, asynchronous mode button level.
REQ-006 SHALL have port btn_run, input, 1 bit: raw, asynchronous run/adjust button level.
REQ-007 SHALL have port en100hz, output, 1 bit: divider 100 Hz rate enable.
REQ-008 SHALL have port en1hz, output, 1 bit: divider 1 Hz rate enable.
REQ-009 SHALL have port en2hz, output, 1 bit: divider 2 Hz rate enable.
REQ-010 SHALL have port mode, output, 2 bits: current mode, or target mode during GUARD; CLOCK=0, SET=1, SW_PAUSE=2, SW_RUN=3.
REQ-011 SHALL have port switching, output, 1 bit: high while in GUARD.
REQ-012 SHALL have port inc_pulse, output, 1 bit: one-cycle time-adjust strobe.
REQ-013 SHALL have port sw_clr, output, 1 bit: one-cycle stopwatch-clear strobe.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer plus a third history flop; an event is sync2 & ~hist, high for exactly one cycle per press.
REQ-015 SHALL register its state on the second rising edge after the edge that first samples a button high (edges k, k+1, state update at k+2).
REQ-016 SHALL implement the states GUARD, CLOCK, SET, SW_PAUSE and SW_RUN, with a 2-bit target register used by GUARD.
REQ-017 SHALL in CLOCK drive en1hz=1 and the other enables 0; mode event -> GUARD(target SET); run event ignored.
REQ-018 SHALL in SET drive en2hz=1 and the other enables 0.
REQ-019 SHALL in SET handle events as follows: run event -> inc_pulse=1 for that cycle and timeout counter cleared; mode event -> GUARD(target SW_PAUSE) with sw_clr=1 for that cycle.
REQ-020 SHALL in SET enter GUARD(target CLOCK) when the timeout counter reaches SET_TIMEOUT-1 with no event in that cycle.
REQ-021 SHALL in SW_PAUSE drive all enables 0; run event -> SW_RUN directly, with no guard; mode event -> GUARD(target CLOCK).
REQ-022 SHALL in SW_RUN drive en100hz=1; run event -> SW_PAUSE directly, with no guard; mode event -> GUARD(target CLOCK).
REQ-023 SHALL in GUARD drive all enables 0, count from 0 and enter the target state when the count equals GUARD_CYCLES-1, so the gap is exactly GUARD_CYCLES cycles.
REQ-024 SHALL drop, not queue, any button event arriving during GUARD.
REQ-025 SHALL give a mode event priority when both events arrive in the same cycle; the run event is dropped and inc_pulse stays 0.
REQ-026 SHALL give a mode event priority over SET timeout expiry in the same cycle.
REQ-027 SHALL clear the SET timeout counter on every entry to SET.
REQ-028 SHALL keep at most one of en100hz, en1hz, en2hz high in any cycle.
REQ-029 SHALL register all outputs so that they change on the same edge as the state, with no combinational path from any input to any output.
REQ-030 SHALL size the counters as clog2 of their parameter, with no wrap-around while in their owning state.

Reset
REQ-031 SHALL, on a clk edge with rst_n=0, set state=GUARD, target=CLOCK, guard count=0, timeout count=0 and all three synchronizer/history flops=1.
REQ-032 SHALL, on a clk edge with rst_n=0, set en100hz=en1hz=en2hz=0, inc_pulse=0, sw_clr=0, switching=1 and mode=0.
REQ-033 SHALL, after rst_n rises, raise en1hz exactly GUARD_CYCLES cycles later; a button held through reset generates no event until it is released and pressed again.
REQ-034 SHALL let reset asserted mid-operation, including mid-GUARD or in SW_RUN, override all other activity on that edge.

Verification (GUARD_CYCLES=4, SET_TIMEOUT=20)
REQ-035 SHALL cover power-up: rst_n low 3 cycles then high -> switching=1 and enables 0 for 4 cycles, then en1hz=1, mode=0, switching=0.
REQ-036 SHALL cover the full mode walk: mode presses -> CLOCK, SET (en2hz), SW_PAUSE (sw_clr pulse, all enables 0), then CLOCK; each change has a 4-cycle all-zero gap.
REQ-037 SHALL cover the stopwatch: in SW_PAUSE, run press -> en100hz=1 on edge k+2 with no gap; second run press -> en100hz=0, mode=2.
REQ-038 SHALL cover SET timeout: enter SET, no presses -> GUARD(target 0) after 20 cycles; a run press at cycle 15 -> inc_pulse for 1 cycle and expiry 20 cycles after that press.
REQ-039 SHALL cover simultaneous events: mode and run rise on the same edge in SET -> GUARD(target 2), sw_clr=1, inc_pulse=0.
REQ-040 SHALL cover the reset and guard corners: rst_n pulsed low in SW_RUN -> enables 0 next edge; a press inside GUARD is ignored and the target is unchanged.

Source files
------------

// File: rtl/rate_seq_ctrl.sv
// rate_seq_ctrl: two-button mode sequencer for a clock/stopwatch divider.
// Selects which divider rate enable is live (1 Hz clock, 2 Hz set blink,
// 100 Hz stopwatch) and inserts an all-enables-low guard gap between rates.
// Every output is registered and updates on the same edge as the state.

module rate_seq_ctrl #(
    parameter int GUARD_CYCLES = 4,
    parameter int SET_TIMEOUT  = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_run,
    output logic       en100hz,
    output logic       en1hz,
    output logic       en2hz,
    output logic [1:0] mode,
    output logic       switching,
    output logic       inc_pulse,
    output logic       sw_clr
);

    // A one-cycle guard still needs a one-bit counter to hold the value 0.
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int TW = $clog2(SET_TIMEOUT);

    localparam logic [GW-1:0] GUARD_LAST   = GW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SET_TIMEOUT - 1);

    localparam logic [1:0] M_CLOCK    = 2'd0;
    localparam logic [1:0] M_SET      = 2'd1;
    localparam logic [1:0] M_SW_PAUSE = 2'd2;
    localparam logic [1:0] M_SW_RUN   = 2'd3;

    typedef enum logic [2:0] {
        ST_GUARD,
        ST_CLOCK,
        ST_SET,
        ST_SW_PAUSE,
        ST_SW_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      target_q, target_d;
    logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic            mode_sync1, mode_sync2, mode_hist;
    logic            run_sync1, run_sync2, run_hist;
    logic            mode_ev, run_ev;

    logic            en100hz_d, en1hz_d, en2hz_d;
    logic [1:0]      mode_d;
    logic            switching_d, inc_pulse_d, sw_clr_d;

    // Resetting to 1 means a button held through reset reads as "already seen"
    // and must be released and pressed again before it produces an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sync1 <= 1'b1;
            mode_sync2 <= 1'b1;
            mode_hist  <= 1'b1;
            run_sync1  <= 1'b1;
            run_sync2  <= 1'b1;
            run_hist   <= 1'b1;
        end else begin
            mode_sync1 <= btn_mode;
            mode_sync2 <= mode_sync1;
            mode_hist  <= mode_sync2;
            run_sync1  <= btn_run;
            run_sync2  <= run_sync1;
            run_hist   <= run_sync2;
        end
    end

    assign mode_ev = mode_sync2 & ~mode_hist;
    assign run_ev  = run_sync2 & ~run_hist;

    // State register, with the registered outputs updated alongside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_GUARD;
            target_q    <= M_CLOCK;
            guard_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            en100hz     <= 1'b0;
            en1hz       <= 1'b0;
            en2hz       <= 1'b0;
            mode        <= M_CLOCK;
            switching   <= 1'b1;
            inc_pulse   <= 1'b0;
            sw_clr      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            guard_cnt_q <= guard_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            en100hz     <= en100hz_d;
            en1hz       <= en1hz_d;
            en2hz       <= en2hz_d;
            mode        <= mode_d;
            switching   <= switching_d;
            inc_pulse   <= inc_pulse_d;
            sw_clr      <= sw_clr_d;
        end
    end

    // Next-state logic; the mode event always wins over run and over timeout.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        guard_cnt_d = guard_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        unique case (state_q)
            ST_GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    unique case (target_q)
                        M_CLOCK:    state_d = ST_CLOCK;
                        M_SET:      state_d = ST_SET;
                        M_SW_PAUSE: state_d = ST_SW_PAUSE;
                        default:    state_d = ST_SW_RUN;
                    endcase
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
            ST_CLOCK: begin
                if (mode_ev) begin
                    state_d     = ST_GUARD;
                    target_d    = M_SET;
                    guard_cnt_d = '0;
                end
            end
            ST_SET: begin
                if (mode_ev) begin
                    state_d     = ST_GUARD;
                    target_d    = M_SW_PAUSE;
                    guard_cnt_d = '0;
                end else if (run_ev) begin
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_GUARD;
                    target_d    = M_CLOCK;
                    guard_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_SW_PAUSE: begin
                if (mode_ev) begin
                    state_d     = ST_GUARD;
                    target_d    = M_CLOCK;
                    guard_cnt_d = '0;
                end else if (run_ev) begin
                    state_d = ST_SW_RUN;
                end
            end
            ST_SW_RUN: begin
                if (mode_ev) begin
                    state_d     = ST_GUARD;
                    target_d    = M_CLOCK;
                    guard_cnt_d = '0;
                end else if (run_ev) begin
                    state_d = ST_SW_PAUSE;
                end
            end
            default: begin
                state_d     = ST_GUARD;
                target_d    = M_CLOCK;
                guard_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs and state share an edge.
    always_comb begin
        en100hz_d   = (state_d == ST_SW_RUN);
        en1hz_d     = (state_d == ST_CLOCK);
        en2hz_d     = (state_d == ST_SET);
        switching_d = (state_d == ST_GUARD);
        inc_pulse_d = (state_q == ST_SET) && run_ev && !mode_ev;
        sw_clr_d    = (state_q == ST_SET) && mode_ev;
        unique case (state_d)
            ST_GUARD:    mode_d = target_d;
            ST_CLOCK:    mode_d = M_CLOCK;
            ST_SET:      mode_d = M_SET;
            ST_SW_PAUSE: mode_d = M_SW_PAUSE;
            ST_SW_RUN:   mode_d = M_SW_RUN;
            default:     mode_d = M_CLOCK;
        endcase
    end

endmodule

// File: tb/tb_rate_seq_ctrl.sv
// tb_rate_seq_ctrl: directed scoreboard bench for rate_seq_ctrl
// (GUARD_CYCLES=4, SET_TIMEOUT=20). Stimulus schedules the expected output
// word for an absolute cycle; a monitor compares it when that cycle arrives.

module tb_rate_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_run;
    logic       en100hz, en1hz, en2hz;
    logic [1:0] mode;
    logic       switching, inc_pulse, sw_clr;

    // Output word layout: {en100hz, en1hz, en2hz, mode[1:0], switching, inc_pulse, sw_clr}
    localparam logic [7:0] P_CLOCK  = 8'b0_1_0_00_0_0_0;
    localparam logic [7:0] P_SET    = 8'b0_0_1_01_0_0_0;
    localparam logic [7:0] P_SETINC = 8'b0_0_1_01_0_1_0;
    localparam logic [7:0] P_PAUSE  = 8'b0_0_0_10_0_0_0;
    localparam logic [7:0] P_RUN    = 8'b1_0_0_11_0_0_0;

    typedef struct {
        int         at;
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   c, d, e, f, g, p, r, q;

    rate_seq_ctrl #(
        .GUARD_CYCLES(4),
        .SET_TIMEOUT (20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_run  (btn_run),
        .en100hz  (en100hz),
        .en1hz    (en1hz),
        .en2hz    (en2hz),
        .mode     (mode),
        .switching(switching),
        .inc_pulse(inc_pulse),
        .sw_clr   (sw_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] guardPat(input logic [1:0] t, input logic clr);
        return {3'b000, t, 1'b1, 1'b0, clr};
    endfunction

    task automatic expectAt(input int at, input string nm, input logic [7:0] pat);
        exp_t item;
        item.at   = at;
        item.name = nm;
        item.exp  = pat;
        sbq.push_back(item);
    endtask

    task automatic applyStimulus(input logic m, input logic rn);
        btn_mode = m;
        btn_run  = rn;
    endtask

    task automatic pressBtns(input logic m, input logic rn, output int at);
        at = cyc;
        applyStimulus(m, rn);
    endtask

    task automatic releaseBtns();
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic checkOutput(input exp_t item, input logic [7:0] act, input int now);
        checks++;
        if (item.at < now) begin
            $display("[TB] FAIL %s: expected at cycle %0d was never sampled (now %0d), required %b",
                     item.name, item.at, now, item.exp);
        end else if (act !== item.exp) begin
            $display("[TB] FAIL %s @%0d: actual %b required %b", item.name, now, act, item.exp);
        end else begin
            passes++;
        end
    endtask

    // Monitor: sample just after each rising edge and retire due entries.
    always @(posedge clk) begin
        #1;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].at <= cyc) begin
                checkOutput(sbq[i], {en100hz, en1hz, en2hz, mode, switching, inc_pulse, sw_clr}, cyc);
                sbq.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        expectAt(1, "reset_state", guardPat(2'd0, 1'b0));
        expectAt(2, "reset_state", guardPat(2'd0, 1'b0));

        // Power-up: release after three reset edges, guard gap, then CLOCK.
        waitUntil(3);
        rst_n = 1'b1;
        expectAt(4, "powerup_gap", guardPat(2'd0, 1'b0));
        expectAt(5, "powerup_gap", guardPat(2'd0, 1'b0));
        expectAt(6, "powerup_gap", guardPat(2'd0, 1'b0));
        expectAt(7, "powerup_clock", P_CLOCK);
        waitUntil(9);

        // Run press in CLOCK is ignored.
        pressBtns(1'b0, 1'b1, c);
        expectAt(c + 3, "clock_run_ignored", P_CLOCK);
        expectAt(c + 5, "clock_run_ignored", P_CLOCK);
        releaseBtns();

        // CLOCK -> SET, then run press at SET cycle 15 restarts the timeout.
        pressBtns(1'b1, 1'b0, c);
        expectAt(c + 3, "clock_to_set_gap", guardPat(2'd1, 1'b0));
        expectAt(c + 6, "clock_to_set_gap", guardPat(2'd1, 1'b0));
        expectAt(c + 7, "set_entry", P_SET);
        releaseBtns();
        p = c + 19;
        waitUntil(p);
        pressBtns(1'b0, 1'b1, p);
        expectAt(p + 3, "set_inc_pulse", P_SETINC);
        expectAt(p + 4, "set_inc_single", P_SET);
        expectAt(c + 27, "set_no_early_expiry", P_SET);
        expectAt(p + 22, "set_before_expiry", P_SET);
        expectAt(p + 23, "set_expiry_after_inc", guardPat(2'd0, 1'b0));
        expectAt(p + 27, "timeout_to_clock", P_CLOCK);
        releaseBtns();
        waitUntil(p + 28);

        // Plain timeout: no presses in SET.
        pressBtns(1'b1, 1'b0, c);
        expectAt(c + 7, "set_entry2", P_SET);
        expectAt(c + 26, "set_last_cycle", P_SET);
        expectAt(c + 27, "set_timeout", guardPat(2'd0, 1'b0));
        expectAt(c + 31, "timeout_clock2", P_CLOCK);
        releaseBtns();
        waitUntil(c + 32);

        // Mode walk: CLOCK -> SET -> SW_PAUSE with sw_clr, stopwatch, back to CLOCK.
        pressBtns(1'b1, 1'b0, c);
        expectAt(c + 7, "walk_set", P_SET);
        releaseBtns();
        waitUntil(c + 8);
        pressBtns(1'b1, 1'b0, d);
        expectAt(d + 3, "walk_swclr", guardPat(2'd2, 1'b1));
        expectAt(d + 4, "walk_swclr_single", guardPat(2'd2, 1'b0));
        expectAt(d + 7, "walk_pause", P_PAUSE);
        releaseBtns();
        waitUntil(d + 8);
        pressBtns(1'b0, 1'b1, e);
        expectAt(e + 2, "sw_still_paused", P_PAUSE);
        expectAt(e + 3, "sw_run_no_gap", P_RUN);
        releaseBtns();
        pressBtns(1'b0, 1'b1, f);
        expectAt(f + 2, "sw_still_running", P_RUN);
        expectAt(f + 3, "sw_pause_no_gap", P_PAUSE);
        releaseBtns();
        pressBtns(1'b1, 1'b0, g);
        expectAt(g + 3, "pause_to_clock_gap", guardPat(2'd0, 1'b0));
        expectAt(g + 7, "walk_clock", P_CLOCK);
        releaseBtns();
        waitUntil(g + 8);

        // Simultaneous mode and run in SET: mode wins, no inc_pulse.
        pressBtns(1'b1, 1'b0, c);
        expectAt(c + 7, "simul_set", P_SET);
        releaseBtns();
        waitUntil(c + 8);
        pressBtns(1'b1, 1'b1, d);
        expectAt(d + 3, "simul_mode_wins", guardPat(2'd2, 1'b1));
        expectAt(d + 7, "simul_pause", P_PAUSE);
        releaseBtns();
        waitUntil(d + 8);

        // Run press landing inside GUARD is dropped; target stays CLOCK.
        pressBtns(1'b1, 1'b0, g);
        expectAt(g + 3, "guard_entry", guardPat(2'd0, 1'b0));
        expectAt(g + 5, "guard_press_dropped", guardPat(2'd0, 1'b0));
        expectAt(g + 6, "guard_press_dropped", guardPat(2'd0, 1'b0));
        expectAt(g + 7, "guard_target_kept", P_CLOCK);
        expectAt(g + 8, "guard_no_queued_evt", P_CLOCK);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        waitUntil(g + 10);

        // Reach SW_RUN, then reset with mode held through it.
        pressBtns(1'b1, 1'b0, c);
        releaseBtns();
        waitUntil(c + 8);
        pressBtns(1'b1, 1'b0, c);
        releaseBtns();
        waitUntil(c + 8);
        pressBtns(1'b0, 1'b1, e);
        expectAt(e + 3, "pre_reset_run", P_RUN);
        releaseBtns();
        r = cyc;
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0);
        expectAt(r + 1, "reset_in_run", guardPat(2'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        expectAt(r + 4, "post_reset_gap", guardPat(2'd0, 1'b0));
        expectAt(r + 5, "post_reset_clock", P_CLOCK);
        expectAt(r + 8, "held_btn_no_event", P_CLOCK);
        waitUntil(r + 10);
        applyStimulus(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        pressBtns(1'b1, 1'b0, q);
        expectAt(q + 3, "repress_after_reset", guardPat(2'd1, 1'b0));
        releaseBtns();
        waitUntil(q + 10);

        repeat (2) @(negedge clk);
        while (sbq.size() > 0) begin
            checks++;
            $display("[TB] FAIL %s: expectation for cycle %0d left unchecked, required %b",
                     sbq[0].name, sbq[0].at, sbq[0].exp);
            void'(sbq.pop_front());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
